// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio source scheduler
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int FRAME_LEN = 256;
    localparam int SAMPLE_W  = 16;
    localparam int GAP_MAX   = 15;

endpackage

// File: rtl/audio_src_scheduler_if.sv
// rtl/audio_src_scheduler_if.sv - source-side and speaker-side signal bundle of the scheduler
interface audio_src_scheduler_if #(
    parameter int NUM_SRC  = 4,
    parameter int SAMPLE_W = 16
);
    logic [NUM_SRC-1:0]          req;
    logic [NUM_SRC*SAMPLE_W-1:0] src_left;
    logic [NUM_SRC*SAMPLE_W-1:0] src_right;
    logic                        mute;
    logic [SAMPLE_W-1:0]         au_in_left;
    logic [SAMPLE_W-1:0]         au_in_right;
    logic [NUM_SRC-1:0]          grant;
    logic [NUM_SRC-1:0]          ack;
    logic                        busy;
    logic                        frame_sync;

    modport master (
        output req, src_left, src_right, mute,
        input  au_in_left, au_in_right, grant, ack, busy, frame_sync
    );

    modport slave (
        input  req, src_left, src_right, mute,
        output au_in_left, au_in_right, grant, ack, busy, frame_sync
    );
endinterface

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - lowest-index-first priority encoder
module prio_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/audio_src_scheduler.sv
// rtl/audio_src_scheduler.sv - frame-synchronous fixed-priority speaker path arbiter
module audio_src_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FRAME_BITS = 8,
    parameter int GAP_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_src_scheduler_if.slave bus
);
    import audio_pkg::*;

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GW = $clog2(GAP_MAX + 1);

    logic [FRAME_BITS-1:0] frame_cnt_q;
    state_t                state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [SAMPLE_W-1:0]   left_q, left_d, right_q, right_d;
    logic [NUM_SRC-1:0]    grant_q, grant_d, ack_q, ack_d;

    logic                  at_b;
    logic                  win_valid, hp_valid;
    logic [IW-1:0]         win_idx, hp_idx;
    logic [NUM_SRC-1:0]    owner_oh, hp_req;
    logic                  idle_like, take;
    logic [IW-1:0]         sel_idx;

    assign at_b     = &frame_cnt_q;
    assign owner_oh = NUM_SRC'(1) << owner_q;
    // Only sources strictly above the owner in priority may preempt it.
    assign hp_req   = bus.req & (owner_oh - NUM_SRC'(1));

    prio_pick #(.N(NUM_SRC), .IW(IW)) u_win (
        .req   (bus.req),
        .valid (win_valid),
        .idx   (win_idx)
    );

    prio_pick #(.N(NUM_SRC), .IW(IW)) u_hp (
        .req   (hp_req),
        .valid (hp_valid),
        .idx   (hp_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            gap_q       <= '0;
            left_q      <= '0;
            right_q     <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + FRAME_BITS'(1);
            state_q     <= state_d;
            owner_q     <= owner_d;
            gap_q       <= gap_d;
            left_q      <= left_d;
            right_q     <= right_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gap_d     = gap_q;
        left_d    = left_q;
        right_d   = right_q;
        grant_d   = grant_q;
        ack_d     = '0;
        take      = 1'b0;
        sel_idx   = owner_q;
        // The last gap frame boundary arbitrates exactly like IDLE.
        idle_like = (state_q != ST_PLAY) && !(state_q == ST_GAP && gap_q > GW'(1));

        if (at_b) begin
            left_d  = '0;
            right_d = '0;
            if (idle_like) begin
                gap_d = '0;
                if (win_valid) begin
                    state_d = ST_PLAY;
                    owner_d = win_idx;
                    sel_idx = win_idx;
                    take    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end else if (state_q == ST_PLAY) begin
                if (!bus.req[owner_q] || hp_valid) begin
                    state_d = ST_GAP;
                    gap_d   = GW'(GAP_FRAMES);
                    grant_d = '0;
                end else begin
                    take = 1'b1;
                end
            end else begin
                gap_d = gap_q - GW'(1);
            end
        end

        if (take) begin
            ack_d   = NUM_SRC'(1) << sel_idx;
            grant_d = NUM_SRC'(1) << sel_idx;
            if (!bus.mute) begin
                left_d  = bus.src_left[int'(sel_idx)*SAMPLE_W +: SAMPLE_W];
                right_d = bus.src_right[int'(sel_idx)*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign bus.au_in_left  = left_q;
    assign bus.au_in_right = right_q;
    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.frame_sync  = (frame_cnt_q == '0);
endmodule

// File: doc/audio_src_scheduler.md
# audio_src_scheduler

Frame-synchronous scheduler that shares the stereo speaker output path between several sound sources (music player, key beep, alarm, …). Once per audio frame it picks one source by fixed priority, latches that source's left/right sample, and acknowledges it so the source can advance. It inserts a short run of silent frames on every source switch to suppress clicks. Its `au_in_left` and `au_in_right` outputs drive the speaker controller's 16-bit sample inputs. Its frame counter runs in lock-step with the speaker controller's 8-bit word-select counter.

## Interface
- `NUM_SRC`, default 4: number of requesters, range 2–8; index 0 has the highest priority.
- `SAMPLE_W`, default 16: sample width in bits.
- `FRAME_BITS`, default 8: frame counter width; frame length is 2^FRAME_BITS clk cycles (256).
- `GAP_FRAMES`, default 2: silent frames inserted on a source change, range 1–15.

- `clk`  in  1  system clock (40 MHz), the same clock as the speaker controller.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_SRC  per-source play request; a level, held while the source has audio.
- `src_left`  in  NUM_SRC*SAMPLE_W  flattened left samples; source i occupies `[i*SAMPLE_W +: SAMPLE_W]`.
- `src_right`  in  NUM_SRC*SAMPLE_W  flattened right samples, same packing.
- `mute`  in  1  forces zero output samples; the scheduler keeps running.
- `au_in_left`  out  SAMPLE_W  latched left sample for the speaker controller.
- `au_in_right`  out  SAMPLE_W  latched right sample.
- `grant`  out  NUM_SRC  one-hot current owner; all zero in IDLE and GAP.
- `ack`  out  NUM_SRC  one-cycle pulse to the source whose sample was just latched.
- `busy`  out  1  high when state is not IDLE.
- `frame_sync`  out  1  high when `frame_cnt == 0`.

## Operation
- `frame_cnt` is a free-running FRAME_BITS-bit counter that wraps from 255 to 0. The frame boundary is the cycle with `frame_cnt == 255`, called B.
- All decisions, latches and state changes take effect only on the clock edge that ends cycle B. Changes on `req` at any other time are ignored.
- The winner is the lowest index i with `req[i] == 1`.
- IDLE
  - At B with any `req` high: go to PLAY with owner = winner. Latch the owner's samples and pulse its `ack`.
  - Otherwise: stay in IDLE with outputs at 0.
- PLAY(g)
  - At B with `req[g]` low, or any `req[j]` high with j < g: go to GAP. Load `gap_cnt = GAP_FRAMES`, latch zeros, no `ack`, `grant` becomes 0.
  - Otherwise: latch source g's samples and pulse `ack[g]`.
- GAP
  - At B, decrement `gap_cnt`, keep outputs at zero, no `ack`.
  - At the B where `gap_cnt == 1`, behave as IDLE, so exactly GAP_FRAMES zero frames are output.
- `mute == 1` at B latches zeros instead of source data. State, `grant` and `ack` are unaffected.
- Within PLAY, a lower-priority request never preempts. A source re-requesting after it drops still passes through GAP.
- If `req[g]` falls and a higher-priority request rises in the same B, the transition is a single GAP. The winner is chosen only at the end of the gap.

## Timing
- The sample is captured from `src_left` and `src_right` at the edge ending B. `au_in_*` are valid from the `frame_cnt == 0` cycle and are held stable for all 256 cycles.
- `ack[g]` is registered and is high during the `frame_cnt == 0` cycle only. The source must present its next sample before the following B, a window of 255 cycles.
- Latency from a `req` rise to the first sample output is at most 256 cycles, plus GAP_FRAMES*256 cycles when the rise forces a switch.
- `grant` and `busy` update on the same edge as `au_in_*`.
- Reset values:
  - `frame_cnt = 0`, state IDLE, `gap_cnt = 0`.
  - `au_in_*`, `grant` and `ack` are 0.
  - `busy` is 0.
  - `frame_sync` is 1 while `frame_cnt == 0`.
- `rst` mid-frame or mid-gap overrides everything on the next edge, with no ack and no partial latch. `rst` must be released on the same edge as the speaker controller's reset so that both counters stay aligned.

## Structure
- Shared package `audio_pkg`:
  - state encoding: IDLE, PLAY, GAP;
  - `FRAME_LEN = 256`;
  - `SAMPLE_W = 16`;
  - `GAP_MAX = 15`.
- One sub-module, `prio_pick`: a parameterised lowest-index-first priority encoder with outputs `valid` and `idx`. It is used for the winner and the preempt check.
- Everything else is one always block for the state and frame counter, plus a registered output stage.

## Test plan
- Reset, then `req = 0000` for 3 frames: outputs stay 0, `busy = 0`, `frame_sync` pulses every 256 cycles.
- `req[2] = 1` with left = 0x1234 and right = 0xABCD, raised mid-frame: at the next B, `grant = 0100` and `ack[2]` is pulsed at `frame_cnt == 0`. From then on `au_in_left = 0x1234` and `au_in_right = 0xABCD`, stable for 256 cycles.
- While source 2 plays, raise `req[0]` with left = right = 0x7FFF: output is 2 zero frames (512 cycles, `grant = 0`), then `grant = 0001` and samples are 0x7FFF.
- While source 0 plays, raise `req[3]`: no change, with `ack[0]` every frame. Then drop `req[0]`: 2 zero frames, then `grant = 1000`.
- `mute = 1` for one frame during PLAY: that frame outputs 0, `ack` still pulses and `grant` is unchanged. After `mute` is released, the next frame outputs source data.
- Assert `rst` at `frame_cnt = 100` during GAP: next cycle all outputs are 0 and the state is IDLE. The first `ack` comes 256 cycles after `rst` release, at `frame_cnt == 0`.
